// File: rtl/bus_cycle_term.sv
// ============================================================================
// Module   : bus_cycle_term
// Brief    : 68000 bus-cycle terminator. Takes registered chip selects from
//            the address decoder and the synchronised address strobe, applies
//            per-device wait states and drives DTACK or BERR back to the CPU.
//            Unmapped, multiply-selected and timed-out cycles end in BERR.
// Options  : BUS_CYCLE_TERM_FAULT_CAPTURE_EN - latch the cause of the last
//            bus error on fault_code, cleared by fault_clr.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module bus_cycle_term #(
    parameter int CNT_W      = 8,
    parameter int ROM_WAIT   = 3,
    parameter int RAM_WAIT   = 1,
    parameter int IO_WAIT    = 4,
    parameter int GFX_WAIT   = 2,
    parameter int CTRL_WAIT  = 0,
    parameter int PGTBL_WAIT = 0,
    parameter int TIMEOUT    = 255
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       as_n,
    input  logic       csunmap,
    input  logic       csram1,
    input  logic       csram2,
    input  logic       csrom,
    input  logic       csio,
    input  logic       csgfx,
    input  logic       csctrl,
    input  logic       cspgtbl,
    input  logic       io_ready,
    input  logic       fault_clr,
    output logic       dtack_n,
    output logic       berr_n,
    output logic       cycle_active,
    output logic [1:0] fault_code
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_ACK  = 2'd2;
    localparam logic [1:0] S_ERR  = 2'd3;

    localparam logic [1:0] F_NONE    = 2'b00;
    localparam logic [1:0] F_UNMAP   = 2'b01;
    localparam logic [1:0] F_MULTI   = 2'b10;
    localparam logic [1:0] F_TIMEOUT = 2'b11;

    localparam logic [CNT_W-1:0] CNT_MAX   = '1;
    localparam logic [CNT_W-1:0] TMO_LIM   = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] W_ROM     = CNT_W'(ROM_WAIT);
    localparam logic [CNT_W-1:0] W_RAM     = CNT_W'(RAM_WAIT);
    localparam logic [CNT_W-1:0] W_IO      = CNT_W'(IO_WAIT);
    localparam logic [CNT_W-1:0] W_GFX     = CNT_W'(GFX_WAIT);
    localparam logic [CNT_W-1:0] W_CTRL    = CNT_W'(CTRL_WAIT);
    localparam logic [CNT_W-1:0] W_PGTBL   = CNT_W'(PGTBL_WAIT);

    logic [1:0]       state, state_nx;
    logic [CNT_W-1:0] tcnt, tcnt_nx, tcnt_inc;
    logic [CNT_W-1:0] wcnt, wcnt_nx;
    logic [CNT_W-1:0] dev_wait;
    logic             io_sel, io_sel_nx;
    logic [3:0]       cs_cnt;
    logic             timeout_due;
    logic [1:0]       err_cause;
    logic             enter_err;

    assign cs_cnt = {3'b000, csunmap} + {3'b000, csram1} + {3'b000, csram2}
                  + {3'b000, csrom}   + {3'b000, csio}   + {3'b000, csgfx}
                  + {3'b000, csctrl}  + {3'b000, cspgtbl};

    // Strobe-to-now counter saturates so a hung cycle can never wrap back
    // below the timeout limit.
    assign tcnt_inc    = (tcnt == CNT_MAX) ? tcnt : tcnt + 1'b1;
    assign timeout_due = (tcnt >= TMO_LIM);
    assign enter_err   = (state_nx == S_ERR) && (state != S_ERR);

    // Wait-state lookup for the single selected device (only used when exactly one cs is high)
    always_comb begin
        dev_wait = '0;
        if (csram1 || csram2) dev_wait = W_RAM;
        else if (csrom)       dev_wait = W_ROM;
        else if (csio)        dev_wait = W_IO;
        else if (csgfx)       dev_wait = W_GFX;
        else if (csctrl)      dev_wait = W_CTRL;
        else if (cspgtbl)     dev_wait = W_PGTBL;
    end

    // Next-state, counter and fault-cause decisions for the bus cycle
    always_comb begin
        state_nx  = state;
        tcnt_nx   = tcnt;
        wcnt_nx   = wcnt;
        io_sel_nx = io_sel;
        err_cause = F_NONE;
        case (state)
            S_IDLE: begin
                if (as_n) begin
                    tcnt_nx = '0;
                    wcnt_nx = '0;
                end else begin
                    tcnt_nx = tcnt_inc;
                    // Decoder has one cycle of latency, so "no cs yet" just waits.
                    if (cs_cnt > 4'd1) begin
                        state_nx  = S_ERR;
                        err_cause = F_MULTI;
                    end else if (csunmap) begin
                        state_nx  = S_ERR;
                        err_cause = F_UNMAP;
                    end else if (timeout_due) begin
                        state_nx  = S_ERR;
                        err_cause = F_TIMEOUT;
                    end else if (cs_cnt == 4'd1) begin
                        state_nx  = S_WAIT;
                        wcnt_nx   = dev_wait;
                        io_sel_nx = csio;
                    end
                end
            end
            S_WAIT: begin
                if (as_n) begin
                    // Aborted cycle: drop back silently.
                    state_nx = S_IDLE;
                    tcnt_nx  = '0;
                    wcnt_nx  = '0;
                end else begin
                    tcnt_nx = tcnt_inc;
                    if (wcnt != '0) begin
                        wcnt_nx = wcnt - 1'b1;
                        if (timeout_due) begin
                            state_nx  = S_ERR;
                            err_cause = F_TIMEOUT;
                        end
                    end else if (!io_sel || io_ready) begin
                        // Acknowledge beats a timeout falling due on the same edge.
                        state_nx = S_ACK;
                    end else if (timeout_due) begin
                        state_nx  = S_ERR;
                        err_cause = F_TIMEOUT;
                    end
                end
            end
            S_ACK, S_ERR: begin
                // Hold the termination until the CPU lifts its strobe.
                if (as_n) begin
                    state_nx = S_IDLE;
                    tcnt_nx  = '0;
                    wcnt_nx  = '0;
                end
            end
            default: begin
                state_nx = S_IDLE;
                tcnt_nx  = '0;
                wcnt_nx  = '0;
            end
        endcase
    end

    // State, counters and registered bus outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= S_IDLE;
            tcnt         <= '0;
            wcnt         <= '0;
            io_sel       <= 1'b0;
            dtack_n      <= 1'b1;
            berr_n       <= 1'b1;
            cycle_active <= 1'b0;
        end else begin
            state        <= state_nx;
            tcnt         <= tcnt_nx;
            wcnt         <= wcnt_nx;
            io_sel       <= io_sel_nx;
            dtack_n      <= (state_nx != S_ACK);
            berr_n       <= (state_nx != S_ERR);
            // A strobed cycle is live exactly while the strobe is sampled low.
            cycle_active <= !as_n;
        end
    end

`ifdef BUS_CYCLE_TERM_FAULT_CAPTURE_EN
    // Latch the cause of each bus error; a new fault beats a clear request
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fault_code <= F_NONE;
        end else if (enter_err) begin
            fault_code <= err_cause;
        end else if (fault_clr) begin
            fault_code <= F_NONE;
        end
    end
`else
    logic       unused_fault;
    assign unused_fault = fault_clr ^ enter_err ^ (|err_cause);
    assign fault_code   = F_NONE;
`endif

endmodule

`default_nettype wire

// File: tb/tb_bus_cycle_term.sv
// ============================================================================
// Module   : tb_bus_cycle_term
// Brief    : Self-checking bench for bus_cycle_term. Each bus cycle is
//            described by its decode edge, device and strobe length; the
//            expected termination edge is derived arithmetically and every
//            edge of the cycle is compared against it.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_bus_cycle_term;

    localparam int TIMEOUT = 255;
    localparam int T_EDGE  = TIMEOUT + 1;   // strobe edge on which timeout BERR appears

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       as_n = 1'b1;
    logic [7:0] cs = 8'h00;                 // 0 ram1,1 ram2,2 rom,3 io,4 gfx,5 ctrl,6 pgtbl,7 unmap
    logic       io_ready = 1'b0;
    logic       fault_clr = 1'b0;
    logic       dtack_n, berr_n, cycle_active;
    logic [1:0] fault_code;

    int         n_tests = 0;
    int         n_fail  = 0;
    logic [1:0] fexp    = 2'b00;
    bit         clr_en  = 1'b0;
    int         wait_of [0:6] = '{1, 1, 3, 4, 2, 0, 0};

    bus_cycle_term #(.TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst_n(rst_n), .as_n(as_n),
        .csunmap(cs[7]), .csram1(cs[0]), .csram2(cs[1]), .csrom(cs[2]),
        .csio(cs[3]), .csgfx(cs[4]), .csctrl(cs[5]), .cspgtbl(cs[6]),
        .io_ready(io_ready), .fault_clr(fault_clr),
        .dtack_n(dtack_n), .berr_n(berr_n), .cycle_active(cycle_active),
        .fault_code(fault_code)
    );

    always #10 clk = ~clk;

    // One bus cycle. dev: 0..6 valid device, 7 unmapped, 8 two devices, 9 none.
    // The strobe is low for low_fix edges if low_fix>0, otherwise for E+hold
    // edges (E = terminating edge), or a random shorter time when abort is set.
    task automatic run_txn(input int dev, input int dly, input int hold, input int low_fix,
                           input bit abort, input int gap, input bit noise,
                           input int io_hi_from, input string name);
        bit         io_pat [1:600];
        int         d_edge, e_edge, a_edge, low_len, i, j;
        bit         is_ack, term;
        logic [1:0] cause;
        logic [7:0] sel;
        d_edge = dly + 1;
        for (int e = 1; e <= 600; e++)
            io_pat[e] = (io_hi_from < 0) ? 1'($urandom % 2) : (e >= io_hi_from);
        is_ack = 1'b0;
        cause  = 2'b11;
        sel    = 8'h00;
        if (dev == 9) begin
            e_edge = T_EDGE;
        end else if (dev == 7) begin
            sel = 8'h80; e_edge = d_edge; cause = 2'b01;
        end else if (dev == 8) begin
            i = $urandom_range(0, 6);
            j = (i + 1 + $urandom_range(0, 5)) % 7;
            sel = (8'h01 << i) | (8'h01 << j); e_edge = d_edge; cause = 2'b10;
        end else begin
            sel    = 8'h01 << dev;
            a_edge = d_edge + wait_of[dev] + 1;
            if (dev == 3)
                while (a_edge <= T_EDGE && !io_pat[a_edge]) a_edge++;
            if (a_edge <= T_EDGE) begin
                e_edge = a_edge; is_ack = 1'b1;
            end else begin
                e_edge = T_EDGE;
            end
        end
        if (low_fix > 0)            low_len = low_fix;
        else if (abort && e_edge > 1) low_len = $urandom_range(1, e_edge - 1);
        else                        low_len = e_edge + hold;

        for (int r = 1; r <= low_len + 1 + gap; r++) begin
            @(negedge clk);
            as_n      = (r > low_len);
            if (r > low_len + 1)          cs = 8'($urandom);
            else if (r < d_edge || dev == 9) cs = 8'h00;
            else if (r == d_edge || !noise)  cs = sel;
            else                          cs = 8'($urandom);
            io_ready  = (r <= 600) ? io_pat[r] : 1'b1;
            fault_clr = clr_en ? ($urandom % 4 == 0) : 1'b0;
            @(posedge clk);
            #1;
            term = (e_edge <= low_len) && (r >= e_edge) && (r <= low_len);
`ifdef BUS_CYCLE_TERM_FAULT_CAPTURE_EN
            if (e_edge <= low_len && r == e_edge && !is_ack) fexp = cause;
            else if (fault_clr)                              fexp = 2'b00;
`endif
            n_tests += 4;
            if (cycle_active !== (r <= low_len)) begin
                n_fail++;
                $display("FAIL %s edge %0d cycle_active got %b exp %b", name, r, cycle_active, (r <= low_len));
            end
            if (dtack_n !== !(term && is_ack)) begin
                n_fail++;
                $display("FAIL %s edge %0d dtack_n got %b exp %b", name, r, dtack_n, !(term && is_ack));
            end
            if (berr_n !== !(term && !is_ack)) begin
                n_fail++;
                $display("FAIL %s edge %0d berr_n got %b exp %b", name, r, berr_n, !(term && !is_ack));
            end
            if (fault_code !== fexp) begin
                n_fail++;
                $display("FAIL %s edge %0d fault_code got %b exp %b", name, r, fault_code, fexp);
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; as_n = 1'b1; cs = 8'h00; io_ready = 1'b0; fault_clr = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_tests++;
        if ({dtack_n, berr_n, cycle_active, fault_code} !== 5'b11000) begin
            n_fail++;
            $display("FAIL reset_values got %b exp 11000", {dtack_n, berr_n, cycle_active, fault_code});
        end
        @(negedge clk); rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk); cs = 8'($urandom);
            @(posedge clk); #1;
            n_tests++;
            if ({dtack_n, berr_n, cycle_active} !== 3'b110) begin
                n_fail++;
                $display("FAIL idle_after_reset got %b exp 110", {dtack_n, berr_n, cycle_active});
            end
        end
        // Reset in the middle of a ROM wait.
        repeat (2) begin
            @(negedge clk); as_n = 1'b0; cs = 8'h04;
            @(posedge clk);
        end
        #3;
        n_tests++;
        if (cycle_active !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_wait_active got %b exp 1", cycle_active);
        end
        rst_n = 1'b0;
        #1;
        n_tests++;
        if ({dtack_n, berr_n, cycle_active} !== 3'b110) begin
            n_fail++;
            $display("FAIL reset_mid_wait got %b exp 110", {dtack_n, berr_n, cycle_active});
        end
        @(negedge clk); rst_n = 1'b1; as_n = 1'b1; cs = 8'h00;
        // Reset while DTACK is being held.
        repeat (3) begin
            @(negedge clk); as_n = 1'b0; cs = 8'h01;
            @(posedge clk);
        end
        #3;
        n_tests++;
        if (dtack_n !== 1'b0) begin
            n_fail++;
            $display("FAIL ack_before_reset dtack_n got %b exp 0", dtack_n);
        end
        rst_n = 1'b0;
        #1;
        n_tests++;
        if ({dtack_n, berr_n, cycle_active} !== 3'b110) begin
            n_fail++;
            $display("FAIL reset_mid_ack got %b exp 110", {dtack_n, berr_n, cycle_active});
        end
        fexp = 2'b00;
        @(negedge clk); rst_n = 1'b1; as_n = 1'b1; cs = 8'h00;
    endtask

    task automatic test_ram_read();
        run_txn(0, 1, 2, 0, 1'b0, 1, 1'b0, -1, "ram1_read");
        run_txn(1, 0, 0, 0, 1'b0, 1, 1'b1, -1, "ram2_read");
    endtask

    task automatic test_unmapped();
        run_txn(7, 0, 1, 0, 1'b0, 1, 1'b0, -1, "unmapped");
    endtask

    task automatic test_slow_io();
        run_txn(3, 0, 2, 0, 1'b0, 1, 1'b0, 16, "io_slow");
        run_txn(3, 0, 1, 0, 1'b0, 1, 1'b0, 1, "io_ready_high");
    endtask

    task automatic test_timeout_conflict();
        run_txn(9, 0, 2, 0, 1'b0, 1, 1'b0, -1, "timeout_no_cs");
        run_txn(3, 0, 1, 0, 1'b0, 1, 1'b0, 400, "timeout_io");
        run_txn(8, 0, 1, 0, 1'b0, 1, 1'b0, -1, "multi_select");
    endtask

    task automatic test_fault_clr();
        run_txn(8, 1, 1, 0, 1'b0, 0, 1'b0, -1, "multi_before_clr");
        @(negedge clk); fault_clr = 1'b1; as_n = 1'b1;
        @(posedge clk); #1;
        fexp = 2'b00;
        n_tests++;
        if (fault_code !== fexp) begin
            n_fail++;
            $display("FAIL fault_clr fault_code got %b exp %b", fault_code, fexp);
        end
        @(negedge clk); fault_clr = 1'b0;
    endtask

    task automatic test_back_to_back();
        run_txn(4, 0, 0, 2, 1'b0, 0, 1'b0, -1, "abort_gfx");
        run_txn(2, 0, 1, 0, 1'b0, 0, 1'b0, -1, "rom_after_abort");
        run_txn(5, 0, 0, 0, 1'b0, 0, 1'b0, -1, "ctrl_zero_wait");
        run_txn(6, 1, 0, 0, 1'b0, 1, 1'b0, -1, "pgtbl_zero_wait");
    endtask

    task automatic test_random();
        clr_en = 1'b1;
        for (int k = 0; k < 40; k++)
            run_txn($urandom_range(0, 8), $urandom_range(0, 2), $urandom_range(0, 3), 0,
                    ($urandom % 4 == 0), $urandom_range(0, 3), 1'($urandom % 2), -1, "random");
        clr_en = 1'b0;
    endtask

    initial begin
        test_reset();
        test_ram_read();
        test_unmapped();
        test_slow_io();
        test_timeout_conflict();
        test_fault_clr();
        test_back_to_back();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
